// File: rtl/mips_pc_pkg.sv
// Shared types for the PC sequencer: branch-kind codes (common with the decoder)
// and the sequencer state set.
package mips_pc_pkg;

  typedef enum logic [6:0] {
    NONE   = 7'd0,
    BEQ    = 7'd30,
    BGEZ   = 7'd31,
    BGEZAL = 7'd32,
    BGTZ   = 7'd33,
    BLEZ   = 7'd34,
    BLTZ   = 7'd35,
    BLTZAL = 7'd36,
    BNE    = 7'd37,
    J      = 7'd38,
    JAL    = 7'd39,
    JALR   = 7'd40,
    JR     = 7'd41
  } branch_kind_t;

  typedef enum logic [1:0] {
    RUN,
    DELAY,
    HALTED,
    FAULT
  } pc_state_t;

  function automatic logic is_reg_jump(input branch_kind_t kind);
    return (kind == JR) || (kind == JALR);
  endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch resolution: taken decision, redirect target and
// misaligned register-jump detection for the instruction at pc_i.
module pc_target_calc
  import mips_pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  branch_kind_t      branch_kind_i,
  input  logic [15:0]       offset_i,
  input  logic [25:0]       instr_index_i,
  input  logic [ADDR_W-1:0] register_data_i,
  input  logic              zero_i,
  input  logic              positive_i,
  input  logic              negative_i,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              misaligned_o
);

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] j_tgt;
  logic [ADDR_W-1:0] jr_tgt;

  assign seq_pc = pc_i + ADDR_W'(4);
  assign br_tgt = seq_pc + {{(ADDR_W-18){offset_i[15]}}, offset_i, 2'b00};
  // J keeps the region bits above bit 27 of the sequential PC (none when ADDR_W == 28)
  assign j_tgt  = (seq_pc & ({ADDR_W{1'b1}} << 28)) | ADDR_W'({instr_index_i, 2'b00});
  assign jr_tgt = {register_data_i[ADDR_W-1:2], 2'b00};

  assign misaligned_o = ALIGN_CHECK && is_reg_jump(branch_kind_i) && (register_data_i[1:0] != 2'b00);

  always_comb begin
    taken_o  = 1'b0;
    target_o = br_tgt;
    case (branch_kind_i)
      BEQ:           taken_o = zero_i;
      BNE:           taken_o = !zero_i;
      BGTZ:          taken_o = positive_i;
      BLEZ:          taken_o = zero_i | negative_i;
      BGEZ, BGEZAL:  taken_o = positive_i | zero_i;
      BLTZ, BLTZAL:  taken_o = negative_i;
      J, JAL: begin
        taken_o  = 1'b1;
        target_o = j_tgt;
      end
      JR, JALR: begin
        taken_o  = 1'b1;
        target_o = jr_tgt;
      end
      default:       taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multicycle MIPS core: delay slots, link
// address, halt on HALT_ADDR and misaligned register-jump faulting.
module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h0,
  parameter bit          DELAY_SLOT   = 1'b1,
  parameter bit          ALIGN_CHECK  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  branch_kind_t      branch_kind,
  input  logic [15:0]       offset,
  input  logic [25:0]       instr_index,
  input  logic [ADDR_W-1:0] register_data,
  input  logic              zero,
  input  logic              positive,
  input  logic              negative,
  output logic [ADDR_W-1:0] address,
  output logic [ADDR_W-1:0] link_address,
  output logic              in_delay_slot,
  output logic              pc_halt,
  output logic              pc_fault
);

  localparam logic [ADDR_W-1:0] RV       = RESET_VECTOR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] HA       = HALT_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] LINK_OFS = DELAY_SLOT ? ADDR_W'(8) : ADDR_W'(4);

  pc_state_t         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] target_q;
  logic              in_ds_q;
  logic              halt_q;
  logic              fault_q;

  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              misaligned;
  logic [ADDR_W-1:0] addr_d;
  logic              halt_hit;

  pc_target_calc #(
    .ADDR_W      (ADDR_W),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_calc (
    .pc_i            (addr_q),
    .branch_kind_i   (branch_kind),
    .offset_i        (offset),
    .instr_index_i   (instr_index),
    .register_data_i (register_data),
    .zero_i          (zero),
    .positive_i      (positive),
    .negative_i      (negative),
    .taken_o         (taken),
    .target_o        (target),
    .misaligned_o    (misaligned)
  );

  always_comb begin
    addr_d   = addr_q;
    halt_hit = 1'b0;
    case (state_q)
      RUN: begin
        addr_d   = (taken && !DELAY_SLOT) ? target : addr_q + ADDR_W'(4);
        halt_hit = !misaligned && (addr_d == HA);
      end
      DELAY: begin
        addr_d   = target_q;
        halt_hit = (addr_d == HA);
      end
      default: addr_d = addr_q;
    endcase
  end

  // A halt on the sequential step into a delay slot wins over latching the branch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RUN;
      addr_q   <= RV;
      target_q <= '0;
      in_ds_q  <= 1'b0;
      halt_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else if (advance) begin
      case (state_q)
        RUN: begin
          if (misaligned) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
          end else begin
            addr_q <= addr_d;
            if (halt_hit) begin
              state_q <= HALTED;
              halt_q  <= 1'b1;
            end else if (taken && DELAY_SLOT) begin
              target_q <= target;
              in_ds_q  <= 1'b1;
              state_q  <= DELAY;
            end
          end
        end
        DELAY: begin
          addr_q  <= addr_d;
          in_ds_q <= 1'b0;
          if (halt_hit) begin
            state_q <= HALTED;
            halt_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign address       = addr_q;
  assign link_address  = addr_q + LINK_OFS;
  assign in_delay_slot = in_ds_q;
  assign pc_halt       = halt_q;
  assign pc_fault      = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: two builds (delay slot + align check, and
// immediate redirect + forced alignment) share one randomized stimulus stream.
module tb_pc_sequencer;
  import mips_pc_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] link;
    logic        ds;
    logic        halt;
    logic        fault;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         advance;
  branch_kind_t branch_kind;
  logic [15:0]  offset;
  logic [25:0]  instr_index;
  logic [31:0]  register_data;
  logic         zero, positive, negative;

  logic [31:0]  addr0, link0, addr1, link1;
  logic         ds0, halt0, fault0, ds1, halt1, fault1;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  logic mon_en  = 1'b0;
  logic sampled = 1'b0;

  logic [31:0] m_addr[2];
  logic [31:0] m_pend[2];
  bit          m_indelay[2];
  bit          m_halt[2];
  bit          m_fault[2];

  branch_kind_t kinds[14] = '{NONE, NONE, BEQ, BGEZ, BGEZAL, BGTZ, BLEZ,
                              BLTZ, BLTZAL, BNE, J, JAL, JALR, JR};

  pc_sequencer dut0 (
    .clk(clk), .reset(reset), .advance(advance), .branch_kind(branch_kind),
    .offset(offset), .instr_index(instr_index), .register_data(register_data),
    .zero(zero), .positive(positive), .negative(negative),
    .address(addr0), .link_address(link0), .in_delay_slot(ds0),
    .pc_halt(halt0), .pc_fault(fault0)
  );

  pc_sequencer #(.DELAY_SLOT(1'b0), .ALIGN_CHECK(1'b0)) dut1 (
    .clk(clk), .reset(reset), .advance(advance), .branch_kind(branch_kind),
    .offset(offset), .instr_index(instr_index), .register_data(register_data),
    .zero(zero), .positive(positive), .negative(negative),
    .address(addr1), .link_address(link1), .in_delay_slot(ds1),
    .pc_halt(halt1), .pc_fault(fault1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: build 0 has delay slot + align check, build 1 has neither.
  task automatic model_load(input int c, input logic [31:0] a);
    m_addr[c] = a;
    if (a == 32'h0) begin
      m_halt[c]    = 1'b1;
      m_indelay[c] = 1'b0;
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_addr[c] = 32'hBFC00000; m_pend[c] = '0;
      m_indelay[c] = 0; m_halt[c] = 0; m_fault[c] = 0;
    end
  endtask

  task automatic model_step(input int c, input branch_kind_t k, input logic [15:0] off,
                            input logic [25:0] idx, input logic [31:0] rd,
                            input logic z, input logic p, input logic n);
    bit          ds_build = (c == 0);
    bit          chk      = (c == 0);
    bit          tk;
    logic [31:0] seq, tgt;
    if (m_halt[c] || m_fault[c]) return;
    if (m_indelay[c]) begin
      m_indelay[c] = 0;
      model_load(c, m_pend[c]);
      return;
    end
    seq = m_addr[c] + 32'd4;
    tgt = seq + {{14{off[15]}}, off, 2'b00};
    tk  = 0;
    case (k)
      BEQ:          tk = z;
      BNE:          tk = !z;
      BGTZ:         tk = p;
      BLEZ:         tk = z | n;
      BGEZ, BGEZAL: tk = p | z;
      BLTZ, BLTZAL: tk = n;
      J, JAL: begin tk = 1; tgt = {seq[31:28], idx, 2'b00}; end
      JR, JALR: begin
        if (chk && rd[1:0] != 2'b00) begin
          m_fault[c] = 1;
          return;
        end
        tk = 1; tgt = {rd[31:2], 2'b00};
      end
      default: tk = 0;
    endcase
    if (!tk) model_load(c, seq);
    else if (ds_build) begin
      m_pend[c]    = tgt;
      m_indelay[c] = 1;
      model_load(c, seq);
    end else model_load(c, tgt);
  endtask

  function automatic exp_t expect_of(input int c);
    exp_t e;
    e.addr  = m_addr[c];
    e.link  = m_addr[c] + ((c == 0) ? 32'd8 : 32'd4);
    e.ds    = m_indelay[c];
    e.halt  = m_halt[c];
    e.fault = m_fault[c];
    return e;
  endfunction

  task automatic check_pop(input int c);
    exp_t e;
    if (c == 0 ? q0.size() == 0 : q1.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_underflow dut%0d actual=empty required=entry", c);
      return;
    end
    e = (c == 0) ? q0.pop_front() : q1.pop_front();
    cmp($sformatf("address%0d", c),  (c == 0) ? addr0 : addr1, e.addr);
    cmp($sformatf("link%0d", c),     (c == 0) ? link0 : link1, e.link);
    cmp($sformatf("delay_slot%0d", c), {31'b0, (c == 0) ? ds0 : ds1},       {31'b0, e.ds});
    cmp($sformatf("halt%0d", c),     {31'b0, (c == 0) ? halt0 : halt1},   {31'b0, e.halt});
    cmp($sformatf("fault%0d", c),    {31'b0, (c == 0) ? fault0 : fault1}, {31'b0, e.fault});
  endtask

  initial begin
    forever begin
      @(posedge clk);
      sampled = mon_en & (advance | ~reset);
      @(negedge clk);
      if (sampled) begin
        check_pop(0);
        check_pop(1);
      end
    end
  end

  task automatic cyc(input logic adv, input branch_kind_t k, input logic [15:0] off,
                     input logic [25:0] idx, input logic [31:0] rd,
                     input logic z, input logic p, input logic n);
    @(negedge clk);
    reset = 1'b1; advance = adv; branch_kind = k; offset = off;
    instr_index = idx; register_data = rd; zero = z; positive = p; negative = n;
    if (adv) begin
      model_step(0, k, off, idx, rd, z, p, n);
      model_step(1, k, off, idx, rd, z, p, n);
      q0.push_back(expect_of(0));
      q1.push_back(expect_of(1));
    end
    @(posedge clk); #1;
  endtask

  task automatic none(input int count);
    for (int i = 0; i < count; i++) cyc(1'b1, NONE, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0; advance = 1'b0;
    #1;
    cmp("async_reset_addr0", addr0, 32'hBFC00000);
    cmp("async_reset_addr1", addr1, 32'hBFC00000);
    cmp("async_reset_flags0", {29'b0, ds0, halt0, fault0}, 32'h0);
    model_reset();
    q0.push_back(expect_of(0));
    q1.push_back(expect_of(1));
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    branch_kind_t k;
    logic [31:0]  rd;
    int           sel, r;
    reset = 1'b0; advance = 1'b0; branch_kind = NONE; offset = '0;
    instr_index = '0; register_data = '0; zero = 0; positive = 0; negative = 0;
    model_reset();
    repeat (2) @(posedge clk);

    do_reset();
    none(3);
    cmp("seq_3_addr0", addr0, 32'hBFC0000C);
    none(1);
    cyc(1'b1, BEQ, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cmp("beq_slot_addr0", addr0, 32'hBFC00014);
    cmp("beq_slot_ds0", {31'b0, ds0}, 32'h1);
    cmp("beq_nods_addr1", addr1, 32'hBFC00020);
    none(1);
    cmp("beq_target_addr0", addr0, 32'hBFC00020);

    do_reset();
    none(4);
    cyc(1'b1, BNE, 16'h0003, 26'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cmp("bne_not_taken_addr0", addr0, 32'hBFC00014);

    do_reset();
    none(16);
    cyc(1'b1, JR, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cmp("jr0_nods_halt1", {31'b0, halt1}, 32'h1);
    none(1);
    cmp("jr0_halt_addr0", addr0, 32'h0);
    cmp("jr0_halt0", {31'b0, halt0}, 32'h1);
    none(2);
    cmp("halt_hold_addr0", addr0, 32'h0);

    do_reset();
    cyc(1'b1, JR, 16'h0, 26'h0, 32'h00001002, 1'b0, 1'b1, 1'b0);
    cmp("misalign_fault0", {31'b0, fault0}, 32'h1);
    cmp("misalign_hold_addr0", addr0, 32'hBFC00000);
    cmp("forced_align_addr1", addr1, 32'h00001000);
    none(1);

    do_reset();
    cyc(1'b1, J, 16'h0, 26'h0000100, 32'h0, 1'b0, 1'b1, 1'b0);
    do_reset();
    none(1);
    cmp("after_delay_reset_addr0", addr0, 32'hBFC00004);

    for (int i = 0; i < 1500; i++) begin
      if (m_halt[0] || m_fault[0] || m_halt[1] || m_fault[1] || $urandom_range(0, 63) == 0)
        do_reset();
      k   = kinds[$urandom_range(0, 13)];
      sel = $urandom_range(0, 2);
      rd  = $urandom;
      r   = $urandom_range(0, 7);
      if (r == 0)      rd = 32'h0;
      else if (r <= 2) rd[1:0] = 2'($urandom_range(1, 3));
      else             rd[1:0] = 2'b00;
      cyc(($urandom_range(0, 3) != 0), k, 16'($urandom), 26'($urandom), rd,
          (sel == 0), (sel == 1), (sel == 2));
    end

    @(negedge clk);
    advance = 1'b0;
    repeat (3) @(negedge clk);
    cmp("scoreboard_drained", 32'(q0.size() + q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
